// File: rtl/sram_like_if.sv
// SRAM-like bus between a core-side master and a memory responder.
// The master drives the request fields; the responder returns the
// accept/response strobes, read data and an occupancy flag.
interface sram_like_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        busy;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata, busy
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata, busy
  );
endinterface

// File: rtl/sram_like_responder.sv
// Responder end of the SRAM-like bus: word-addressed RAM behind an
// in-order response FIFO. Accepts are decoupled from responses so the
// master sees independent addr_ok / data_ok timing.
// Optional macro RANDOM_STALL_EN: when defined, a 16-bit LFSR injects
// pseudo-random stalls on addr_ok and data_ok; when undefined there is
// no LFSR and responses follow accepts with a fixed 1-cycle latency.
module sram_like_responder #(
  parameter int          RAM_AW      = 14,
  parameter int          OUTSTANDING = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [3:0]  STALL_MASK  = 4'b0011
) (
  input logic         clk,
  input logic         resetn,
  sram_like_if.slave  bus
);

  localparam int DEPTH = 1 << RAM_AW;
  localparam int PW    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW    = $clog2(OUTSTANDING + 1);

  logic [31:0]       mem [DEPTH];
  logic [31:0]       fifo_data [OUTSTANDING];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [31:0]       rdata_q;
  logic              run;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              a_stall;
  logic              d_stall;
  logic [RAM_AW-1:0] idx;

  // Size and the address bits outside the word index do not affect behaviour.
  logic unused_bits;
  assign unused_bits = ^{bus.size, bus.addr[31:RAM_AW+2], bus.addr[1:0]};

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(OUTSTANDING - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign idx   = bus.addr[RAM_AW+1:2];
  assign full  = (count == CW'(OUTSTANDING));
  assign empty = (count == '0);

  // Accept and response strobes depend only on registered state, never on req.
  assign bus.addr_ok = run & ~full & ~a_stall;
  assign bus.data_ok = ~empty & ~d_stall;
  assign bus.busy    = ~empty;
  assign bus.rdata   = bus.data_ok ? fifo_data[rd_ptr] : rdata_q;

  assign push = bus.req & bus.addr_ok;
  assign pop  = bus.data_ok;

`ifdef RANDOM_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11, free-running out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= LFSR_SEED;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // A stall fires only when every bit selected by STALL_MASK is set.
  assign a_stall = &(lfsr[3:0] | ~STALL_MASK);
  assign d_stall = &(lfsr[7:4] | ~STALL_MASK);
`else
  assign a_stall = 1'b0;
  assign d_stall = 1'b0;
`endif

  // Control state: run flag holds addr_ok low until the first edge after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run     <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rdata_q <= '0;
    end else begin
      run <= 1'b1;
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop) begin
        rd_ptr  <= ptr_next(rd_ptr);
        rdata_q <= fifo_data[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // RAM byte-lane writes on an accepted write; contents survive reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (push && bus.wr && bus.wstrb[k]) mem[idx][8*k +: 8] <= bus.wdata[8*k +: 8];
    end
  end

  // Response payload captured at accept; writes carry a zero word.
  always_ff @(posedge clk) begin
    if (push) fifo_data[wr_ptr] <= bus.wr ? 32'h0 : mem[idx];
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench for sram_like_responder followed by a scoreboarded
// random traffic run over a small aliased address window.
module tb_sram_like_responder;

  logic clk;
  logic resetn;
  int   vectors;
  int   fails;

  sram_like_if bus ();

  sram_like_responder dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    bus.req   = r;
    bus.wr    = w;
    bus.size  = 2'd2;
    bus.addr  = a;
    bus.wstrb = s;
    bus.wdata = d;
  endtask

  task automatic dstall_free();
`ifdef RANDOM_STALL_EN
    force dut.d_stall = 1'b0;
`else
    release dut.d_stall;
`endif
  endtask

  localparam logic [31:0] A = 32'h1C00_8000;
  localparam logic [31:0] B = 32'h1C00_8004;

  logic [31:0] model [16];
  logic [32:0] expq [$];
  logic [32:0] e;
  logic [31:0] ra;
  logic [31:0] rd;
  logic [3:0]  rs;
  logic        rw;
  logic        rr;
  int          n_acc;
  int          n_resp;
  int          wi;
  bit          saw_astall;
  bit          saw_dgap;

  initial begin
    vectors = 0;
    fails   = 0;
    resetn  = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
`ifdef RANDOM_STALL_EN
    force dut.a_stall = 1'b0;
    force dut.d_stall = 1'b0;
`endif
    #1;
    check("rst_addr_ok", 32'(bus.addr_ok), 32'd0);
    check("rst_data_ok", 32'(bus.data_ok), 32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_rdata",   bus.rdata,        32'h0);
    tick();
    resetn = 1'b1;
    tick();

    // Case 1: word write then read of the same address.
    check("c1_idle_addr_ok", 32'(bus.addr_ok), 32'd1);
    drive(1'b1, 1'b1, A, 4'hF, 32'h1122_3344);
    check("c1_wr_addr_ok", 32'(bus.addr_ok), 32'd1);
    tick();
    drive(1'b1, 1'b0, A, 4'h0, 32'hDEAD_BEEF);
    check("c1_rd_addr_ok", 32'(bus.addr_ok), 32'd1);
    check("c1_wr_data_ok", 32'(bus.data_ok), 32'd1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("c1_rd_data_ok", 32'(bus.data_ok), 32'd1);
    check("c1_rdata",      bus.rdata,        32'h1122_3344);
    tick();
    check("c1_drained_data_ok", 32'(bus.data_ok), 32'd0);
    check("c1_drained_busy",    32'(bus.busy),    32'd0);
    check("c1_rdata_hold",      bus.rdata,        32'h1122_3344);

    // Case 2: single byte lane write, then word read.
    drive(1'b1, 1'b1, A, 4'b0010, 32'h0000_AB00);
    tick();
    drive(1'b1, 1'b0, A | 32'h3, 4'hF, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("c2_data_ok", 32'(bus.data_ok), 32'd1);
    check("c2_rdata",   bus.rdata,        32'h1122_AB44);
    tick();

    // Case 3: fill the FIFO behind a held response stall.
    force dut.d_stall = 1'b1;
    drive(1'b1, 1'b0, A, 4'h0, 32'h0);
    check("c3_first_addr_ok", 32'(bus.addr_ok), 32'd1);
    tick();
    check("c3_stalled_data_ok", 32'(bus.data_ok), 32'd0);
    check("c3_second_addr_ok",  32'(bus.addr_ok), 32'd1);
    drive(1'b1, 1'b1, B, 4'hF, 32'hCAFE_0001);
    tick();
    drive(1'b1, 1'b0, B, 4'h0, 32'h0);
    check("c3_full_addr_ok", 32'(bus.addr_ok), 32'd0);
    check("c3_full_busy",    32'(bus.busy),    32'd1);
    tick();
    check("c3_full_addr_ok_held", 32'(bus.addr_ok), 32'd0);
    dstall_free();
    #1;
    check("c3_pop_data_ok",       32'(bus.data_ok), 32'd1);
    check("c3_pop_rdata",         bus.rdata,        32'h1122_AB44);
    check("c3_no_bypass_addr_ok", 32'(bus.addr_ok), 32'd0);
    tick();
    check("c3_after_pop_addr_ok", 32'(bus.addr_ok), 32'd1);
    check("c3_wr_resp_data_ok",   32'(bus.data_ok), 32'd1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("c3_rd_b_data_ok", 32'(bus.data_ok), 32'd1);
    check("c3_rd_b_rdata",   bus.rdata,        32'hCAFE_0001);
    tick();
    check("c3_drained_busy", 32'(bus.busy), 32'd0);

    // Case 4: read A, write A, read A back-to-back.
    drive(1'b1, 1'b0, A, 4'h0, 32'h0);
    tick();
    drive(1'b1, 1'b1, A, 4'hF, 32'h0000_0005);
    check("c4_r1_data_ok", 32'(bus.data_ok), 32'd1);
    check("c4_r1_rdata",   bus.rdata,        32'h1122_AB44);
    tick();
    drive(1'b1, 1'b0, A, 4'h0, 32'h0);
    check("c4_w_data_ok", 32'(bus.data_ok), 32'd1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("c4_r2_data_ok", 32'(bus.data_ok), 32'd1);
    check("c4_r2_rdata",   bus.rdata,        32'h0000_0005);
    tick();
    check("c4_idle_data_ok", 32'(bus.data_ok), 32'd0);

    // Case 6: reset with two queued responses.
    force dut.d_stall = 1'b1;
    drive(1'b1, 1'b0, A, 4'h0, 32'h0);
    tick();
    tick();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("c6_queued_busy", 32'(bus.busy), 32'd1);
    resetn = 1'b0;
    #1;
    check("c6_rst_addr_ok", 32'(bus.addr_ok), 32'd0);
    check("c6_rst_data_ok", 32'(bus.data_ok), 32'd0);
    check("c6_rst_busy",    32'(bus.busy),    32'd0);
    dstall_free();
    tick();
    resetn = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("c6_no_stale_data_ok", 32'(bus.data_ok), 32'd0);
      tick();
    end
    drive(1'b1, 1'b0, A, 4'h0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("c6_retain_data_ok", 32'(bus.data_ok), 32'd1);
    check("c6_retain_rdata",   bus.rdata,        32'h0000_0005);
    tick();

    // Case 5: random traffic against a scoreboard.
`ifdef RANDOM_STALL_EN
    release dut.a_stall;
    release dut.d_stall;
`endif
    n_acc      = 0;
    n_resp     = 0;
    saw_astall = 1'b0;
    saw_dgap   = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (n_acc < 16) begin
        rr = 1'b1;
        rw = 1'b1;
        wi = n_acc;
        rs = 4'hF;
      end else begin
        rr = ($urandom_range(0, 3) != 0);
        rw = $urandom_range(0, 1) == 1;
        wi = $urandom_range(0, 15);
        rs = 4'($urandom_range(0, 15));
      end
      rd = $urandom;
      ra = {16'($urandom), 16'h9000 + 16'(wi * 4) + 16'($urandom_range(0, 3))};
      drive(rr, rw, ra, rs, rd);
      #1;
      if (bus.data_ok) begin
        if (expq.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          n_resp++;
          if (!e[32]) check("sb_rdata", bus.rdata, e[31:0]);
        end
      end else if (bus.busy) begin
        saw_dgap = 1'b1;
      end
      if (!bus.addr_ok) saw_astall = 1'b1;
      if (bus.req && bus.addr_ok) begin
        n_acc++;
        if (rw) begin
          for (int k = 0; k < 4; k++) if (rs[k]) model[wi][8*k +: 8] = rd[8*k +: 8];
          expq.push_back({1'b1, 32'h0});
        end else begin
          expq.push_back({1'b0, model[wi]});
        end
      end
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int cyc = 0; cyc < 64 && expq.size() != 0; cyc++) begin
      if (bus.data_ok) begin
        e = expq.pop_front();
        n_resp++;
        if (!e[32]) check("sb_drain_rdata", bus.rdata, e[31:0]);
      end
      tick();
    end
    check("sb_resp_count", 32'(n_resp), 32'(n_acc));
    check("sb_final_busy", 32'(bus.busy), 32'd0);
`ifdef RANDOM_STALL_EN
    check("sb_saw_addr_stall", 32'(saw_astall), 32'd1);
    check("sb_saw_data_gap",   32'(saw_dgap),   32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
